io_port: RTL and testbench
==========================

// Module: io_port
// PURPOSE
//  Memory-mapped I/O responder for mycpu: the device end of the CU's I/O access (iom/wen).
//  Decodes CPU IOR/IOW accesses into four registers. Buffers outbound words in a TX FIFO
//  toward an external valid/ready stream, and inbound words in an RX FIFO.
//  Sits beside the datapath; its read data feeds the datapath's I/O input mux.
// PARAMETERS
//  DEPTH  4   entries per FIFO; power of two, 2..64
//  DW     16  data word width
// PORTS
//  clk       in   1   system clock, all state on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  iom_in    in   1   1 = current CPU access targets I/O space
//  wen_in    in   1   active-low write enable: 0 = write, 1 = read
//  addr_in   in   16  I/O address; only [1:0] decoded, [15:2] ignored
//  data_in   in   DW  CPU write data
//  data_out  out  DW  CPU read data, combinational, zero wait states
//  tx_valid  out  1   TX FIFO head valid
//  tx_data   out  DW  TX FIFO head word
//  tx_ready  in   1   external sink accepts head
//  rx_valid  in   1   external source offers word
//  rx_data   in   DW  inbound word
//  rx_ready  out  1   = !rx_full
// BEHAVIOUR
//  - Register map (addr_in[1:0]):
//      0 TXDATA (W)
//      1 RXDATA (R, pops)
//      2 STATUS (R)
//      3 CTRL (W)
//  - wr = iom_in & !wen_in; rd = iom_in & wen_in; evaluated every cycle they are high.
//  - Write TXDATA: push data_in. If TX is full, the word is dropped and the FIFO is unchanged.
//  - Read RXDATA:
//      - non-empty: data_out = head, and head is popped at the clock edge.
//      - empty: data_out = 0, no pop.
//  - STATUS:
//      bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full,
//      bit4 tx_ovf, bit5 rx_ovf, [7:6]=0, [15:8] rx_count zero-extended.
//  - Reads of addresses 0 and 3, and writes to 1 and 2: data_out = 0 and no side effect.
//  - CTRL write:
//      bit0 flushes TX; bit1 flushes RX; bit2 clears the ovf flags.
//      Flush wins over a same-cycle push or pop on that FIFO.
//  - TX side:
//      tx_valid = !tx_empty; tx_data = head.
//      Pop when tx_valid & tx_ready.
//      A write in cycle N is visible on tx_valid/tx_data at cycle N+1.
//  - RX side:
//      Push when rx_valid & rx_ready.
//      A push in cycle N is readable at cycle N+1. rx_ready is low when full, so no overflow occurs.
//  - Simultaneous push and pop on a non-empty FIFO: count unchanged, FIFO order preserved.
//  - On a full FIFO, a pop and a push in the same cycle are both accepted.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - Count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
//  - Reset, including mid-transfer: both FIFOs empty, all pointers and counts 0, ovf flags 0.
//    Outputs: tx_valid=0, tx_data=0, rx_ready=1, data_out=0 unless rd, STATUS=16'h0005.
//  - Storage contents are not reset; tx_data is masked to 0 when the FIFO is empty.
// CONFIGURATION
//  MYCPU_IO_OVF_EN defined: sticky overflow flags.
//    tx_ovf sets when a TXDATA write hits a full TX FIFO.
//    rx_ovf sets when rx_valid is high while rx_ready is low.
//    Both clear on reset or CTRL bit2.
//    Same-cycle set and clear: set wins.
//  MYCPU_IO_OVF_EN undefined: STATUS bits 4/5 read 0; no flag registers are built.
// STRUCTURE
//  mycpu_pkg additions:
//    io_addr_t enum {IO_TXDATA=2'd0, IO_RXDATA, IO_STATUS, IO_CTRL}
//    localparams IO_ST_* bit indices
//    localparams IO_CTRL_FLUSH_TX / IO_CTRL_FLUSH_RX / IO_CTRL_CLR_OVF
//  Sub-module io_fifo (DEPTH, DW):
//    inputs push, pop, flush
//    outputs head, full, empty, count
//    instantiated twice, once for TX and once for RX.
//  Top level: address decode, STATUS assembly, ovf flags.
// TESTING
//  1. Reset pulse mid-stream, then a STATUS read -> 16'h0005; tx_valid=0; rx_ready=1.
//  2. IOW TXDATA 16'hA5A5 with tx_ready=0 -> next cycle tx_valid=1, tx_data=A5A5.
//     Then tx_ready=1 for 1 cycle -> tx_valid=0.
//  3. Write 5 words 1..5 with tx_ready=0:
//       -> tx_full is set; tx_ovf=1 with the macro, 0 without.
//     Then drain -> words 1,2,3,4 in order, word 5 absent.
//  4. Push RX 16'h1234, 16'h5678, then read RXDATA 3 times -> 1234, 5678, 0000.
//     STATUS[15:8] steps 2,1,0.
//  5. RX holds 1 word; same cycle RXDATA read and rx_valid push of 16'hBEEF:
//       -> rx_count stays 1; the next read returns BEEF.
//  6. Fill RX to 4 -> rx_ready=0. Then write CTRL 16'h0007 -> STATUS=16'h0005 next cycle, rx_ready=1.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared mycpu definitions for the I/O responder: register map, STATUS bit
// positions and CTRL command bits.
package mycpu_pkg;

    typedef enum logic [1:0] {
        IO_TXDATA = 2'd0,
        IO_RXDATA = 2'd1,
        IO_STATUS = 2'd2,
        IO_CTRL   = 2'd3
    } io_addr_t;

    localparam int IO_ST_RX_EMPTY = 0;
    localparam int IO_ST_RX_FULL  = 1;
    localparam int IO_ST_TX_EMPTY = 2;
    localparam int IO_ST_TX_FULL  = 3;
    localparam int IO_ST_TX_OVF   = 4;
    localparam int IO_ST_RX_OVF   = 5;
    localparam int IO_ST_CNT_LSB  = 8;

    localparam int IO_CTRL_FLUSH_TX = 0;
    localparam int IO_CTRL_FLUSH_RX = 1;
    localparam int IO_CTRL_CLR_OVF  = 2;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with flush; head is masked to zero while empty.
// A pop and a push in the same cycle are both accepted, even when full.
module io_fifo
    import mycpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [DW-1:0]              din_i,
    output logic [DW-1:0]              head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_acc_s, push_acc_s;

    assign empty_o    = (count_q == {(AW+1){1'b0}});
    assign full_o     = (count_q == FULL_CNT);
    assign count_o    = count_q;
    assign head_o     = empty_o ? {DW{1'b0}} : mem_q[rd_ptr_q];
    assign pop_acc_s  = pop_i & ~empty_o;
    assign push_acc_s = push_i & (~full_o | pop_acc_s);

    // Pointer and occupancy next-state; flush overrides any same-cycle push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {(AW+1){1'b0}};
        end else begin
            if (push_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_acc_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_acc_s && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/io_port.sv
// mycpu memory-mapped I/O responder: TXDATA/RXDATA/STATUS/CTRL over two FIFOs.
// Define MYCPU_IO_OVF_EN to build the sticky tx_ovf/rx_ovf flags.
module io_port
    import mycpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iom_in,
    input  logic          wen_in,
    input  logic [15:0]   addr_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          rx_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    io_addr_t      addr_s;
    logic          wr_s, rd_s;
    logic          tx_push_s, tx_pop_s, tx_flush_s;
    logic          rx_push_s, rx_pop_s, rx_flush_s, clr_ovf_s;
    logic          tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [DW-1:0] tx_head_s, rx_head_s;
    logic [CW-1:0] tx_count_unused_s, rx_count_s;
    logic [13:0]   addr_unused_s;
    logic          tx_ovf_s, rx_ovf_s;
    logic [15:0]   status_s;

    assign addr_s        = io_addr_t'(addr_in[1:0]);
    assign addr_unused_s = addr_in[15:2];
    assign wr_s          = iom_in & ~wen_in;
    assign rd_s          = iom_in & wen_in;
    assign tx_pop_s      = tx_ready & ~tx_empty_s;
    assign rx_push_s     = rx_valid & ~rx_full_s;
    assign tx_valid      = ~tx_empty_s;
    assign tx_data       = tx_head_s;
    assign rx_ready      = ~rx_full_s;

    assign status_s = {8'(rx_count_s), 2'b00, rx_ovf_s, tx_ovf_s,
                       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};

    // Address decode: FIFO strobes, CTRL commands and zero-wait read data.
    always_comb begin
        tx_push_s  = 1'b0;
        rx_pop_s   = 1'b0;
        tx_flush_s = 1'b0;
        rx_flush_s = 1'b0;
        clr_ovf_s  = 1'b0;
        data_out   = {DW{1'b0}};
        if (wr_s) begin
            case (addr_s)
                IO_TXDATA: tx_push_s = 1'b1;
                IO_CTRL: begin
                    tx_flush_s = data_in[IO_CTRL_FLUSH_TX];
                    rx_flush_s = data_in[IO_CTRL_FLUSH_RX];
                    clr_ovf_s  = data_in[IO_CTRL_CLR_OVF];
                end
                default: tx_push_s = 1'b0;
            endcase
        end else if (rd_s) begin
            case (addr_s)
                IO_RXDATA: begin
                    rx_pop_s = 1'b1;
                    data_out = rx_head_s;
                end
                IO_STATUS: data_out = DW'(status_s);
                default:   data_out = {DW{1'b0}};
            endcase
        end else begin
            data_out = {DW{1'b0}};
        end
    end

    io_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_push_s),
        .pop_i   (tx_pop_s),
        .flush_i (tx_flush_s),
        .din_i   (data_in),
        .head_o  (tx_head_s),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s),
        .count_o (tx_count_unused_s)
    );

    io_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push_s),
        .pop_i   (rx_pop_s),
        .flush_i (rx_flush_s),
        .din_i   (rx_data),
        .head_o  (rx_head_s),
        .full_o  (rx_full_s),
        .empty_o (rx_empty_s),
        .count_o (rx_count_s)
    );

`ifdef MYCPU_IO_OVF_EN
    logic tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic tx_ovf_set_s, rx_ovf_set_s;

    // A write counts as an overflow only if the word is actually dropped.
    assign tx_ovf_set_s = tx_push_s & tx_full_s & ~tx_pop_s;
    assign rx_ovf_set_s = rx_valid & ~rx_ready;
    assign tx_ovf_s     = tx_ovf_q;
    assign rx_ovf_s     = rx_ovf_q;

    // Sticky flag next-state: set beats clear.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        if (tx_ovf_set_s) begin
            tx_ovf_d = 1'b1;
        end else if (clr_ovf_s) begin
            tx_ovf_d = 1'b0;
        end else begin
            tx_ovf_d = tx_ovf_q;
        end
        if (rx_ovf_set_s) begin
            rx_ovf_d = 1'b1;
        end else if (clr_ovf_s) begin
            rx_ovf_d = 1'b0;
        end else begin
            rx_ovf_d = rx_ovf_q;
        end
    end

    // Overflow flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end
`else
    assign tx_ovf_s = 1'b0;
    assign rx_ovf_s = 1'b0;
`endif

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: directed scenarios then random traffic,
// all checked against a queue-based model of the register/FIFO behaviour.
module tb_io_port;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
`ifdef MYCPU_IO_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iom_in, wen_in, tx_ready, rx_valid;
    logic [15:0]   addr_in;
    logic [DW-1:0] data_in, rx_data, data_out, tx_data;
    logic          tx_valid, rx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    bit            m_txovf, m_rxovf;
    logic [DW-1:0] last_do;

    always #5 clk = ~clk;

    io_port #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iom_in   (iom_in),
        .wen_in   (wen_in),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .data_out (data_out),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] st;
        st       = 16'h0000;
        st[0]    = (rxq.size() == 0);
        st[1]    = (rxq.size() == DEPTH);
        st[2]    = (txq.size() == 0);
        st[3]    = (txq.size() == DEPTH);
        st[4]    = m_txovf;
        st[5]    = m_rxovf;
        st[15:8] = 8'(rxq.size());
        return st;
    endfunction

    task automatic m_reset();
        txq.delete();
        rxq.delete();
        m_txovf = 1'b0;
        m_rxovf = 1'b0;
    endtask

    // One clock cycle: drive, check outputs against the model, clock, update model.
    task automatic step(input logic iom, input logic wen, input logic [15:0] addr,
                        input logic [DW-1:0] data, input logic txr, input logic rxv,
                        input logic [DW-1:0] rxd);
        logic [1:0]    a;
        logic          m_rd, m_wr, exp_txv, exp_rxr, tx_pop, tx_wr, tx_acc, ctrl;
        logic [DW-1:0] exp_txd, exp_do;
        iom_in = iom; wen_in = wen; addr_in = addr; data_in = data;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        #1;
        a       = addr[1:0];
        m_rd    = iom & wen;
        m_wr    = iom & ~wen;
        exp_txv = (txq.size() != 0);
        exp_txd = exp_txv ? txq[0] : 16'h0000;
        exp_rxr = (rxq.size() < DEPTH);
        exp_do  = 16'h0000;
        if (m_rd && a == 2'd1 && rxq.size() != 0) exp_do = rxq[0];
        if (m_rd && a == 2'd2) exp_do = m_status();
        chk("tx_valid", tx_valid, exp_txv);
        chk("tx_data", tx_data, exp_txd);
        chk("rx_ready", rx_ready, exp_rxr);
        chk("data_out", data_out, exp_do);
        last_do = data_out;
        @(posedge clk);
        tx_pop = exp_txv & txr;
        tx_wr  = m_wr & (a == 2'd0);
        tx_acc = tx_wr & ((txq.size() < DEPTH) | tx_pop);
        ctrl   = m_wr & (a == 2'd3);
        if (tx_pop) void'(txq.pop_front());
        if (tx_acc) txq.push_back(data);
        if (m_rd && a == 2'd1 && rxq.size() != 0) void'(rxq.pop_front());
        if (rxv && exp_rxr) rxq.push_back(rxd);
        if (ctrl && data[0]) txq.delete();
        if (ctrl && data[1]) rxq.delete();
        if (OVF_EN) begin
            m_txovf = (tx_wr & ~tx_acc) | (m_txovf & ~(ctrl & data[2]));
            m_rxovf = (rxv & ~exp_rxr)  | (m_rxovf & ~(ctrl & data[2]));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask
    task automatic iow(input logic [15:0] addr, input logic [DW-1:0] d);
        step(1'b1, 1'b0, addr, d, 1'b0, 1'b0, 16'h0000);
    endtask
    task automatic ior(input logic [15:0] addr);
        step(1'b1, 1'b1, addr, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask
    task automatic rxpush(input logic [DW-1:0] d);
        step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, d);
    endtask

    initial begin
        rst_n = 1'b0; iom_in = 1'b0; wen_in = 1'b1; addr_in = 16'h0000;
        data_in = 16'h0000; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0000;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: reset mid-stream
        iow(16'h0000, 16'h1111);
        rxpush(16'h2222);
        step(1'b1, 1'b0, 16'h0000, 16'h3333, 1'b1, 1'b1, 16'h4444);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("t1_rst_tx_valid", tx_valid, 1'b0);
        chk("t1_rst_rx_ready", rx_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        ior(16'h0002);
        chk("t1_status", last_do, 16'h0005);

        // Scenario 2: single TX word, then one-cycle drain
        iow(16'h0000, 16'hA5A5);
        chk("t2_tx_valid", tx_valid, 1'b1);
        chk("t2_tx_data", tx_data, 16'hA5A5);
        step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("t2_tx_drained", tx_valid, 1'b0);

        // Scenario 3: overfill TX, then drain in order
        for (int i = 1; i <= 5; i++) iow(16'hFFFC, 16'(i));
        ior(16'h0002);
        chk("t3_tx_full", last_do[3], 1'b1);
        chk("t3_tx_ovf", last_do[4], OVF_EN);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain_word", tx_data, 16'(i));
            step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        end
        chk("t3_drain_empty", tx_valid, 1'b0);

        // Scenario 4: RX push two, read three
        rxpush(16'h1234);
        rxpush(16'h5678);
        ior(16'h0002); chk("t4_cnt2", last_do[15:8], 8'd2);
        ior(16'h0001); chk("t4_rd1", last_do, 16'h1234);
        ior(16'h0002); chk("t4_cnt1", last_do[15:8], 8'd1);
        ior(16'h0001); chk("t4_rd2", last_do, 16'h5678);
        ior(16'h0002); chk("t4_cnt0", last_do[15:8], 8'd0);
        ior(16'h0001); chk("t4_rd_empty", last_do, 16'h0000);

        // Scenario 5: simultaneous RX pop and push
        rxpush(16'h1111);
        step(1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
        chk("t5_pop_head", last_do, 16'h1111);
        ior(16'h0002); chk("t5_cnt", last_do[15:8], 8'd1);
        ior(16'h0001); chk("t5_beef", last_do, 16'hBEEF);

        // Scenario 6: fill RX, offer one more, then flush everything
        for (int i = 0; i < 4; i++) rxpush(16'hC000 + 16'(i));
        chk("t6_rx_ready_full", rx_ready, 1'b0);
        rxpush(16'hDEAD);
        iow(16'h0003, 16'h0007);
        ior(16'h0002);
        chk("t6_status", last_do, 16'h0005);
        chk("t6_rx_ready", rx_ready, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra, rd;
            ra = 16'($urandom());
            rd = 16'($urandom());
            if (ra[1:0] == 2'd3 && $urandom_range(0, 3) != 0) rd[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rd,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom()));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
